// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch PC redirect controller.
package pc_redirect_ctrl_pkg;

    typedef logic [31:0] PC;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        WAIT_DS = 2'd2
    } PC_CTRL_STATE;

    // Redirect request / pending-target bundle.
    typedef struct packed {
        logic enable;
        PC    pc_new;
    } PC_CHECK;

    localparam PC RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam PC EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    function automatic PC pc_seq(input PC p);
        return p + 32'd4;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Fetch, execute-redirect and exception signals around the PC controller.
interface pc_redirect_ctrl_if;
    import pc_redirect_ctrl_pkg::*;

    logic        fetch_ready;
    logic        pipe_stall;
    logic        ex_redirect_valid;
    PC           ex_redirect_pc;
    logic        ex_ds_fetched;
    logic        exc_valid;
    logic        exc_is_eret;
    PC           epc;
    PC           pc;
    logic        pc_valid;
    logic        flush_fetch;
    logic        redirect_pending;
    logic        err_ds_branch;
    logic [31:0] redirect_count;

    // Controller side: owns and presents the PC.
    modport master (
        input  fetch_ready, pipe_stall, ex_redirect_valid, ex_redirect_pc,
               ex_ds_fetched, exc_valid, exc_is_eret, epc,
        output pc, pc_valid, flush_fetch, redirect_pending, err_ds_branch,
               redirect_count
    );

    // Fetch / execute / exception side.
    modport slave (
        output fetch_ready, pipe_stall, ex_redirect_valid, ex_redirect_pc,
               ex_ds_fetched, exc_valid, exc_is_eret, epc,
        input  pc, pc_valid, flush_fetch, redirect_pending, err_ds_branch,
               redirect_count
    );

endinterface

// File: rtl/pc_redirect_ctrl_counter.sv
// Wrapping event counter for applied PC redirects.
module pc_redirect_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc_en)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: sequential advance, EX redirect with delay-slot deferral,
// exception entry and ERET return.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter PC RESET_PC   = RESET_PC_DEFAULT,
    parameter PC EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    pc_redirect_ctrl_if.master bus
);

    PC_CTRL_STATE state;
    PC            pc_q;
    PC_CHECK      pend_q;
    PC_CHECK      ex_req;
    logic         pc_valid_q;
    logic         flush_q;
    logic         pending_q;
    logic         err_q;
    logic         accept;
    logic         ex_now;
    logic         ds_take;
    logic         cnt_inc;
    logic [31:0]  count;

    assign ex_req  = '{enable: bus.ex_redirect_valid, pc_new: bus.ex_redirect_pc};
    assign accept  = pc_valid_q & bus.fetch_ready & ~bus.pipe_stall;
    assign ex_now  = ex_req.enable & (state == RUN) & bus.ex_ds_fetched;
    assign ds_take = (state == WAIT_DS) & pend_q.enable & accept;
    // Exception beats any EX redirect or delay-slot completion in the same cycle.
    assign cnt_inc = bus.exc_valid | ex_now | ds_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            if (bus.exc_valid) begin
                pc_q       <= bus.exc_is_eret ? bus.epc : EXC_VECTOR;
                flush_q    <= 1'b1;
                pend_q     <= '0;
                state      <= RUN;
                pc_valid_q <= 1'b1;
                pending_q  <= 1'b0;
            end else begin
                case (state)
                    BOOT: begin
                        state      <= RUN;
                        pc_valid_q <= 1'b1;
                    end
                    RUN: begin
                        if (ex_now) begin
                            pc_q    <= ex_req.pc_new;
                            flush_q <= 1'b1;
                        end else if (ex_req.enable) begin
                            // Delay slot not fetched yet: keep advancing so it is.
                            pend_q    <= ex_req;
                            state     <= WAIT_DS;
                            pending_q <= 1'b1;
                            if (accept)
                                pc_q <= pc_seq(pc_q);
                        end else if (accept) begin
                            pc_q <= pc_seq(pc_q);
                        end
                    end
                    WAIT_DS: begin
                        if (ex_req.enable)
                            err_q <= 1'b1;
                        if (ds_take) begin
                            pc_q      <= pend_q.pc_new;
                            flush_q   <= 1'b1;
                            pend_q    <= '0;
                            state     <= RUN;
                            pending_q <= 1'b0;
                        end
                    end
                    default: begin
                        state      <= BOOT;
                        pc_valid_q <= 1'b0;
                        pending_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    pc_redirect_counter #(.WIDTH(32)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_en (cnt_inc),
        .count  (count)
    );

    assign bus.pc               = pc_q;
    assign bus.pc_valid         = pc_valid_q;
    assign bus.flush_fetch      = flush_q;
    assign bus.redirect_pending = pending_q;
    assign bus.err_ds_branch    = err_q;
    assign bus.redirect_count   = count;

endmodule
